// File: rtl/ece593w26_mac_ctrl.sv
// ece593w26_mac_ctrl: sequences operand pairs into a multiplier and gates products into an accumulator
module ece593w26_mac_ctrl #(
  parameter int N       = 4,
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  output logic             mul_en,
  input  logic [2*N-1:0]   mul_prod,
  output logic             acc_clr,
  output logic [2*N-1:0]   acc_in,
  output logic             acc_en,
  input  logic [2*N-1:0]   acc_f,
  input  logic             acc_cout,
  output logic [2*N-1:0]   res,
  output logic             res_ovf,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] rem;
  logic [MUL_LAT-1:0] line;
  logic acc_en_d, ovf;
  assign mul_a    = op_a;
  assign mul_b    = op_b;
  assign op_ready = state == RUN && rem != '0;
  assign mul_en   = op_valid & op_ready;
  assign acc_en   = line[MUL_LAT-1];
  assign acc_in   = acc_en ? mul_prod : '0;
  assign acc_clr  = state == CLEAR;
  assign busy     = state inside {CLEAR, RUN, DRAIN};
  assign done     = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (len != '0 ? CLEAR : DONE) : IDLE;
      CLEAR:   state_nx = RUN;
      RUN:     state_nx = (mul_en && rem == LEN_W'(1)) ? DRAIN : RUN;
      DRAIN:   state_nx = line == '0 ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // once the delay line is empty in DRAIN, acc_f already holds the last product and acc_cout its carry
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem      <= '0;
      line     <= '0;
      acc_en_d <= 1'b0;
      ovf      <= 1'b0;
      res      <= '0;
      res_ovf  <= 1'b0;
    end else begin
      line     <= MUL_LAT'({line, mul_en});
      acc_en_d <= acc_en;
      if (state == IDLE && start) rem <= len;
      else if (mul_en) rem <= rem - LEN_W'(1);
      if (state == CLEAR) ovf <= 1'b0;
      else if (acc_en_d && acc_cout) ovf <= 1'b1;
      if (state_nx == DONE) begin
        res     <= state == DRAIN ? acc_f : '0;
        res_ovf <= state == DRAIN && (ovf || (acc_en_d && acc_cout));
      end
    end
endmodule

// File: tb/tb_ece593w26_mac_ctrl.sv
// tb_ece593w26_mac_ctrl: scoreboard bench with multiplier/accumulator models around the controller
module tb_ece593w26_mac_ctrl;
  localparam int N = 4, LEN_W = 8, MUL_LAT = 1;
  logic clk = 0, rst = 0, start = 0, op_valid = 0;
  logic busy, op_ready, mul_en, acc_clr, acc_en, acc_cout, res_ovf, done;
  logic [LEN_W-1:0] len = '0;
  logic [N-1:0] op_a = '0, op_b = '0, mul_a, mul_b;
  logic [2*N-1:0] mul_prod, acc_in, acc_f, res;
  typedef struct {logic [7:0] r; logic o; int n;} exp_t;
  exp_t sb[$];
  exp_t me;
  int checks = 0, failures = 0;
  int pa[32], pb[32];
  int cyc = 0, last_hs = 0, nmul = 0, nacc = 0, nclr = 0;

  always #5 clk = ~clk;

  ece593w26_mac_ctrl #(.N(N), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_prod(mul_prod),
    .acc_clr(acc_clr), .acc_in(acc_in), .acc_en(acc_en), .acc_f(acc_f),
    .acc_cout(acc_cout), .res(res), .res_ovf(res_ovf), .done(done)
  );

  // one-cycle multiplier and carry-out accumulator surrounding the controller
  always @(posedge clk or negedge rst)
    if (!rst) mul_prod <= '0;
    else mul_prod <= mul_a * mul_b;
  always @(posedge clk or negedge rst)
    if (!rst) {acc_cout, acc_f} <= '0;
    else if (acc_clr) {acc_cout, acc_f} <= '0;
    else if (acc_en) {acc_cout, acc_f} <= {1'b0, acc_f} + {1'b0, acc_in};

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // monitor: samples late in each cycle, pops an expectation on every done
  initial forever begin
    @(negedge clk); #3;
    cyc++;
    if (!rst) begin
      nmul = 0; nacc = 0; nclr = 0;
    end else begin
      if (mul_en) begin nmul++; last_hs = cyc; end
      nacc += int'(acc_en);
      nclr += int'(acc_clr);
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          me = sb.pop_front();
          chk("res", res, me.r);
          chk("res_ovf", res_ovf, me.o);
          chk("mul_en_count", nmul, me.n);
          chk("acc_en_count", nacc, me.n);
          chk("acc_clr_count", nclr, me.n != 0);
          chk("busy_in_done", busy, 0);
          if (me.n != 0) chk("done_latency", cyc - last_hs, 3);
        end
        nmul = 0; nacc = 0; nclr = 0;
      end
    end
  end

  // vm: 0 always valid, 1 toggling valid, 2 random valid; sp: spray start while busy and in DONE
  task automatic do_job(input int n, input int vm, input bit sp);
    int sum, i, g;
    exp_t e;
    sum = 0;
    for (int k = 0; k < n; k++) sum += pa[k] * pb[k];
    e.r = sum[7:0];
    e.o = sum > 255;
    e.n = n;
    sb.push_back(e);
    start = 1; len = LEN_W'(n);
    @(negedge clk);
    start = 0;
    i = 0; g = 0;
    while (i < n && g < 500) begin
      op_a = N'(pa[i]); op_b = N'(pb[i]);
      op_valid = vm == 0 ? 1'b1 : vm == 1 ? (g % 2 == 0) : 1'($urandom_range(0, 1));
      start = sp ? 1'($urandom_range(0, 1)) : 1'b0;
      len = LEN_W'($urandom_range(0, 255));
      #1;
      if (op_valid && op_ready) i++;
      @(negedge clk);
      g++;
    end
    if (i < n) chk("handshake_timeout", i, n);
    op_valid = 0; g = 0;
    while (!done && g < 60) begin
      start = sp;
      @(negedge clk);
      g++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_op_ready", op_ready, 0);
    rst = 1;
    @(negedge clk);
    pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
    do_job(3, 0, 0);
    do_job(0, 0, 0);
    pa[0] = 15; pb[0] = 15; pa[1] = 15; pb[1] = 15;
    do_job(2, 0, 0);
    for (int k = 0; k < 3; k++) begin pa[k] = k + 1; pb[k] = 2; end
    do_job(3, 2, 1);
    for (int k = 0; k < 4; k++) begin pa[k] = 2; pb[k] = 3; end
    do_job(4, 1, 0);
    start = 1; len = 8'd6;
    @(negedge clk);
    start = 0; op_a = 3; op_b = 3; op_valid = 1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_op_ready", op_ready, 0);
    chk("mid_rst_acc_en", acc_en, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res", res, 0);
    op_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (12) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int k = 0; k < n; k++) begin
        pa[k] = $urandom_range(0, 15);
        pb[k] = $urandom_range(0, 15);
      end
      do_job(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
